branch_resolve: RTL
===================

# branch_resolve

Execute-stage branch resolution unit for the 16-bit datapath. Consumes the `types_pkg::result_t` produced by the comparator for the branch in EX, decides taken/not-taken from the branch condition, and issues a registered one-cycle PC redirect plus a multi-cycle flush of the younger pipeline stages. It also keeps a saturating count of taken branches for debug.

## Interface
- `PC_W`, 16, width of PC, offset and redirect target
- `FLUSH_CYCLES`, 2, unstalled cycles `flush` stays high after a taken branch (legal 1..7)
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `stall`  in  1  pipeline hold; blocks evaluation, freezes flush countdown
- `br_valid`  in  1  EX holds a branch/jump instruction
- `br_cond`  in  2  00 BLT (LESS), 01 BGT (GREATER), 10 BEQ (EQUAL), 11 JMP (unconditional)
- `cmp_result`  in  `types_pkg::result_t`  comparator output for the EX operands
- `pc_ex`  in  PC_W  PC of the EX instruction
- `offset`  in  PC_W  branch offset, two's complement
- `redirect_valid`  out  1  one-cycle pulse: fetch must load `redirect_pc`
- `redirect_pc`  out  PC_W  branch target, valid while `redirect_valid`
- `flush`  out  1  squash IF/ID contents
- `busy`  out  1  state is FLUSH
- `cmp_err`  out  1  one-cycle pulse: conditional branch evaluated with `cmp_result == UNKNOWN`
- `taken_count`  out  16  saturating count of taken branches

## Operation
- States: IDLE, FLUSH. Reset → IDLE.
- Evaluate event (eval): state IDLE and `br_valid` and not `stall`.
- Taken: JMP always; BLT iff LESS; BGT iff GREATER; BEQ iff EQUAL. UNKNOWN on a conditional branch → not taken, and `cmp_err` pulses the next cycle. JMP never raises `cmp_err`.
- Target: `pc_ex + offset`, modulo 2^PC_W; wrap-around is silent.
- Taken eval: next cycle `redirect_valid`=1 and `redirect_pc`=target; state → FLUSH; `flush`=1; down-counter loaded with FLUSH_CYCLES.
- FLUSH: `flush`=`busy`=1. Each cycle without `stall` decrements the counter; on reaching 0, state → IDLE. `stall` holds counter and state; `flush` stays asserted.
- `br_valid` during FLUSH is a squashed instruction: ignored entirely, with no redirect, no count and no `cmp_err`.
- Not-taken eval: no outputs change except a possible `cmp_err`; state stays IDLE; a branch may be evaluated every cycle.
- `taken_count` increments on each taken eval, saturating at 0xFFFF.
- `redirect_pc` holds its last value when `redirect_valid`=0.

## Timing
- Reset (async assert, sync-safe deassert): `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `busy`=0, `cmp_err`=0, `taken_count`=0, state IDLE, counter 0. Asserting reset mid-FLUSH aborts the flush immediately.
- Latency: all outputs are registered. Eval in cycle N gives `redirect_valid`/`cmp_err` in N+1.
- Taken eval in N with no stalls: `flush`/`busy` high in N+1..N+FLUSH_CYCLES. Back in IDLE at N+FLUSH_CYCLES+1, when a new eval is accepted.
- `redirect_valid` is exactly one cycle even if `stall` rises in N+1. Fetch must accept the redirect regardless of stall.
- `stall` in cycle N suppresses eval in N. The branch is evaluated in the first unstalled cycle with `br_valid` still high.

## Test plan
- Reset, then BEQ with EQUAL, `pc_ex`=0x0100, `offset`=0x0010 → N+1 `redirect_valid`=1 and `redirect_pc`=0x0110. `flush` high for N+1, N+2. `taken_count`=1. IDLE at N+3.
- BLT with GREATER, then next cycle BGT with LESS → no redirect, no flush, `taken_count` unchanged. Both evaluated back-to-back.
- JMP with `pc_ex`=0xFFF0, `offset`=0x0020 → `redirect_pc`=0x0010, showing wrap-around. Stall raised in N+2 for 3 cycles → `flush` high N+1..N+5, IDLE at N+6.
- Taken branch, then `br_valid` with JMP during FLUSH → ignored: single redirect, `taken_count` +1 only.
- BEQ with UNKNOWN → `cmp_err` pulses one cycle with no redirect. JMP with UNKNOWN → taken, no `cmp_err`.
- Preload `taken_count` to 0xFFFE via 0xFFFE taken JMPs (or a force), then 2 more → saturates at 0xFFFF. Assert `rst_n` low in mid-FLUSH → all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// types_pkg
//   Shared datapath types. result_t is the relation reported by the
//   comparator for the two EX operands. UNKNOWN covers operands the
//   comparator could not resolve, for example on a forwarding hazard.
// ---------------------------------------------------------------------------
package types_pkg;
    typedef enum logic [1:0] {
        LESS    = 2'b00,
        GREATER = 2'b01,
        EQUAL   = 2'b10,
        UNKNOWN = 2'b11
    } result_t;
endpackage

// ---------------------------------------------------------------------------
// branch_resolve
//   Execute-stage branch resolution. This module decides taken or not-taken
//   from the branch condition and the comparator result. For a taken branch
//   it issues a registered one-cycle PC redirect, then holds a flush of the
//   younger stages for FLUSH_CYCLES unstalled cycles. It also keeps a
//   saturating count of taken branches for debug.
//
// Ports
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall          pipeline hold: blocks evaluation, freezes flush countdown
//   br_valid       EX holds a branch or jump
//   br_cond        00 BLT, 01 BGT, 10 BEQ, 11 JMP
//   cmp_result     comparator relation for the EX operands
//   pc_ex          PC of the EX instruction
//   offset         two's complement branch offset
//   redirect_valid one-cycle pulse: fetch loads redirect_pc
//   redirect_pc    branch target; holds its value between redirects
//   flush          squash IF/ID
//   busy           FSM is in FLUSH
//   cmp_err        one-cycle pulse: conditional branch saw UNKNOWN
//   taken_count    saturating taken-branch counter
// ---------------------------------------------------------------------------
module branch_resolve
    import types_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [1:0]      br_cond,
    input  result_t         cmp_result,
    input  logic [PC_W-1:0] pc_ex,
    input  logic [PC_W-1:0] offset,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic            busy,
    output logic            cmp_err,
    output logic [15:0]     taken_count
);

    localparam logic [1:0] COND_BLT = 2'b00;
    localparam logic [1:0] COND_BGT = 2'b01;
    localparam logic [1:0] COND_BEQ = 2'b10;
    localparam logic [1:0] COND_JMP = 2'b11;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic            cmp_err_q;
    logic [15:0]     taken_count_q;

    logic            eval_d;
    logic            taken_d;
    logic            unknown_d;
    logic [PC_W-1:0] target_d;

    // Branches that arrive during FLUSH are squashed instructions.
    // They never qualify as an eval.
    assign eval_d = (state_q == IDLE) && br_valid && !stall;

    // UNKNOWN matches none of the relations, so a conditional branch that
    // sees it falls through as not taken.
    always_comb begin
        taken_d   = 1'b0;
        unknown_d = 1'b0;
        unique case (br_cond)
            COND_BLT: taken_d = (cmp_result == LESS);
            COND_BGT: taken_d = (cmp_result == GREATER);
            COND_BEQ: taken_d = (cmp_result == EQUAL);
            COND_JMP: taken_d = 1'b1;
            default:  taken_d = 1'b0;
        endcase
        unknown_d = (br_cond != COND_JMP) && (cmp_result == UNKNOWN);
    end

    // Target wraps modulo 2^PC_W.
    assign target_d = pc_ex + offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cmp_err_q        <= 1'b0;
            taken_count_q    <= '0;
        end else begin
            // These pulses are not qualified by stall. A redirect lasts
            // exactly one cycle even if stall rises right after the eval.
            redirect_valid_q <= eval_d && taken_d;
            cmp_err_q        <= eval_d && unknown_d;

            unique case (state_q)
                IDLE: begin
                    if (eval_d && taken_d) begin
                        redirect_pc_q <= target_d;
                        state_q       <= FLUSH;
                        cnt_q         <= FLUSH_LOAD;
                        if (taken_count_q != 16'hFFFF) begin
                            taken_count_q <= taken_count_q + 16'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        if (cnt_q <= 3'd1) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = (state_q == FLUSH);
    assign flush          = (state_q == FLUSH);
    assign cmp_err        = cmp_err_q;
    assign taken_count    = taken_count_q;

endmodule
